cache_miss_seq: RTL and testbench
=================================

Name: cache_miss_seq

Overview:
- Miss sequencer for one 4-way set-associative cache bank in the M stage.
- On a miss it selects a victim way: an invalid way first, otherwise the one-hot LRU way from the set's LRU state machine.
- It writes the victim back to memory if dirty, requests the line fill, then issues a single-cycle tag/way write and an LRU touch, whose one-hot output drives the LRU FSM's update input and enable.

Parameters:
ADDR_W, 32, physical address width
OFF_W, 4, line-offset bits cleared in wb/fill addresses (16B line)
TMO, 255, max cycles waiting for wb_ack/fill_ack before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
miss_valid  in  1  miss request from cache pipeline
miss_ready  out  1  sequencer idle, accepts miss
miss_addr  in  ADDR_W  missing address
set_valid  in  4  valid bits of the indexed set
set_dirty  in  4  dirty bits of the indexed set
lru_way  in  4  one-hot LRU way from LRU FSM
victim_tag_addr  in  ADDR_W  line address of each candidate is supplied per-way by tag array for chosen way (sampled in SEL)
way_sel  out  4  one-hot chosen victim, drives tag-array read mux from SEL onward
wb_req  out  1  writeback request
wb_addr  out  ADDR_W  victim line address, low OFF_W bits 0
wb_ack  in  1  memory accepted writeback
fill_req  out  1  line-fill request
fill_addr  out  ADDR_W  miss_addr with low OFF_W bits 0
fill_ack  in  1  fill data returned and written
tag_we  out  1  tag/valid write strobe
lru_touch  out  4  one-hot touch to LRU FSM (zero when idle)
done  out  1  miss completed pulse
err  out  1  timeout abort pulse

Behaviour:
- All outputs registered (Moore).
- Async reset, any state, mid-operation included:
  - state=IDLE, timeout counter=0, latched regs=0.
  - miss_ready=1; all other outputs 0.
  - A reset during WB or FILL drops the request with no update.
- States: IDLE, SEL, WB, FILL, UPD.
- IDLE:
  - miss_ready=1.
  - miss_valid=1 latches miss_addr, set_valid, set_dirty and lru_way; next state SEL; miss_ready drops the next cycle.
- SEL (1 cycle):
  - victim = lowest-index way with set_valid=0.
  - If all valid, victim = lowest set bit of lru_way; lru_way=0 selects way 0.
  - way_sel=victim from this cycle until the return to IDLE; victim_tag_addr is latched here.
  - Victim valid and dirty -> WB; else -> FILL.
- WB:
  - wb_req=1 and wb_addr held stable until wb_ack is sampled 1; then -> FILL.
  - An ack in the first WB cycle is legal.
- FILL:
  - fill_req=1 and fill_addr held until fill_ack=1; then -> UPD.
- UPD (1 cycle): tag_we=1, lru_touch=way_sel, done=1; -> IDLE.
- Latency, miss accept to done:
  - clean: 3 + fill wait cycles.
  - dirty: 4 + wb wait + fill wait cycles.
- Timeout counter (8-bit):
  - Cleared on entry to WB or FILL; increments each cycle the ack is low.
  - When the count equals TMO with the ack low: err=1 for one cycle, req deasserted, -> IDLE; no tag_we, no lru_touch.
  - Ack in the same cycle the count reaches TMO: ack wins.
- wb_ack and fill_ack outside their own state are ignored.
- miss_valid outside IDLE is ignored; no queueing.
- done and err are never asserted together.

Test Plan:
1. Invalid way present: set_valid=4'b1011, lru_way=4'b0001, miss_addr=0x0000_1234, fill_ack 2 cycles after fill_req -> way_sel=4'b0100, no wb_req, fill_addr=0x0000_1230, UPD tag_we=1 lru_touch=4'b0100 done=1; 5 cycles accept->done.
2. Clean LRU victim: set_valid=4'hF, set_dirty=0, lru_way=4'b1000, fill_ack in first FILL cycle -> way_sel=4'b1000, no wb_req, done 3 cycles after accept.
3. Dirty victim: set_valid=4'hF, set_dirty=4'b0010, lru_way=4'b0010, victim_tag_addr=0x0000_ABCF, wb_ack after 3 cycles, fill_ack after 1 -> wb_addr=0x0000_ABC0, fill_req only after wb_ack, lru_touch=4'b0010.
4. Timeout: TMO=4, fill_ack never arrives -> fill_req high 4 cycles, err=1 one cycle, no tag_we or lru_touch, miss_ready=1 next cycle; repeat with fill_ack on the 4th cycle -> done, no err.
5. Reset mid-WB: assert rst while wb_req=1 -> wb_req=0 and miss_ready=1 immediately (async); new miss after release completes normally.
6. Degenerate and stray inputs: lru_way=0 with all valid -> way_sel=4'b0001; stray fill_ack in IDLE and miss_valid during FILL -> no effect.

Source files
------------

// File: rtl/cache_miss_seq_if.sv
// Miss-sequencer bus: pipeline miss request, set state, tag read-back, memory wb/fill
// handshakes and tag/LRU update strobes.
interface cache_miss_seq_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic [3:0]        set_valid;
  logic [3:0]        set_dirty;
  logic [3:0]        lru_way;
  logic [ADDR_W-1:0] victim_tag_addr;
  logic [3:0]        way_sel;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_ack;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_ack;
  logic              tag_we;
  logic [3:0]        lru_touch;
  logic              done;
  logic              err;

  // Environment side: cache pipeline, tag array, LRU FSM and memory.
  modport master (
    output miss_valid, miss_addr, set_valid, set_dirty, lru_way, victim_tag_addr,
    output wb_ack, fill_ack,
    input  miss_ready, way_sel, wb_req, wb_addr, fill_req, fill_addr, tag_we,
    input  lru_touch, done, err
  );

  // Sequencer side.
  modport slave (
    input  miss_valid, miss_addr, set_valid, set_dirty, lru_way, victim_tag_addr,
    input  wb_ack, fill_ack,
    output miss_ready, way_sel, wb_req, wb_addr, fill_req, fill_addr, tag_we,
    output lru_touch, done, err
  );
endinterface

// File: rtl/cache_miss_seq.sv
// Miss sequencer for one 4-way cache bank: victim select, optional writeback, line fill,
// then a one-cycle tag write and LRU touch. All outputs are registered.
module cache_miss_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned TMO    = 255
) (
  input logic              clk,
  input logic              rst,
  cache_miss_seq_if.slave  bus
);

  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [2:0] {StIdle, StSel, StWb, StFill, StUpd} state_e;

  state_e            state;
  logic [7:0]        cnt;
  logic [3:0]        valid_q;
  logic [3:0]        dirty_q;
  logic              ready_q;
  logic [3:0]        way_q;
  logic              wb_req_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              fill_req_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic              tag_we_q;
  logic [3:0]        touch_q;
  logic              done_q;
  logic              err_q;

  logic [3:0] victim;
  logic [3:0] lru_pick;
  logic       tmo_hit;

  // Victim is resolved at accept so way_sel is already a register during SEL.
  always_comb begin
    lru_pick = 4'b0001;
    if (bus.lru_way[0])      lru_pick = 4'b0001;
    else if (bus.lru_way[1]) lru_pick = 4'b0010;
    else if (bus.lru_way[2]) lru_pick = 4'b0100;
    else if (bus.lru_way[3]) lru_pick = 4'b1000;

    victim = lru_pick;
    if (!bus.set_valid[0])      victim = 4'b0001;
    else if (!bus.set_valid[1]) victim = 4'b0010;
    else if (!bus.set_valid[2]) victim = 4'b0100;
    else if (!bus.set_valid[3]) victim = 4'b1000;
  end

  // Abort on the wait cycle whose increment would make the count reach TMO.
  assign tmo_hit = ({1'b0, cnt} + 9'd1) == 9'(TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      ready_q     <= 1'b1;
      way_q       <= '0;
      wb_req_q    <= 1'b0;
      wb_addr_q   <= '0;
      fill_req_q  <= 1'b0;
      fill_addr_q <= '0;
      tag_we_q    <= 1'b0;
      touch_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tag_we_q <= 1'b0;
      touch_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.miss_valid) begin
            valid_q     <= bus.set_valid;
            dirty_q     <= bus.set_dirty;
            way_q       <= victim;
            fill_addr_q <= bus.miss_addr & ~OffMask;
            ready_q     <= 1'b0;
            state       <= StSel;
          end
        end
        StSel: begin
          cnt <= '0;
          if (|(way_q & valid_q & dirty_q)) begin
            wb_addr_q <= bus.victim_tag_addr & ~OffMask;
            wb_req_q  <= 1'b1;
            state     <= StWb;
          end else begin
            fill_req_q <= 1'b1;
            state      <= StFill;
          end
        end
        StWb: begin
          if (bus.wb_ack) begin
            wb_req_q   <= 1'b0;
            fill_req_q <= 1'b1;
            cnt        <= '0;
            state      <= StFill;
          end else if (tmo_hit) begin
            wb_req_q <= 1'b0;
            err_q    <= 1'b1;
            ready_q  <= 1'b1;
            way_q    <= '0;
            state    <= StIdle;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StFill: begin
          if (bus.fill_ack) begin
            fill_req_q <= 1'b0;
            tag_we_q   <= 1'b1;
            touch_q    <= way_q;
            done_q     <= 1'b1;
            state      <= StUpd;
          end else if (tmo_hit) begin
            fill_req_q <= 1'b0;
            err_q      <= 1'b1;
            ready_q    <= 1'b1;
            way_q      <= '0;
            state      <= StIdle;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StUpd: begin
          ready_q <= 1'b1;
          way_q   <= '0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.miss_ready = ready_q;
  assign bus.way_sel    = way_q;
  assign bus.wb_req     = wb_req_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.fill_req   = fill_req_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.tag_we     = tag_we_q;
  assign bus.lru_touch  = touch_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_cache_miss_seq.sv
// Randomized bench for cache_miss_seq: each miss is predicted from the victim, latency and
// timeout rules and compared against the observed handshake trace.
module tb_cache_miss_seq;

  localparam int unsigned AW  = 32;
  localparam int unsigned OW  = 4;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_miss_seq_if #(.ADDR_W(AW)) bus ();

  cache_miss_seq #(.ADDR_W(AW), .OFF_W(OW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_victim(input logic [3:0] sv, input logic [3:0] lru);
    for (int i = 0; i < 4; i++) if (!sv[i]) return 4'(1 << i);
    for (int i = 0; i < 4; i++) if (lru[i]) return 4'(1 << i);
    return 4'b0001;
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return (a >> OW) << OW;
  endfunction

  task automatic idle_checks();
    check_eq("idle_ctl", {bus.miss_ready, bus.way_sel, bus.wb_req, bus.fill_req, bus.tag_we,
                          bus.lru_touch, bus.done, bus.err}, 14'b1_0000_0_0_0_0000_0_0);
  endtask

  // Cycle 0 = accept cycle, cycle 1 = SEL, cycle 2 = first WB/FILL cycle.
  task automatic run_miss(input logic [AW-1:0] addr, input logic [3:0] sv, input logic [3:0] sd,
                          input logic [3:0] lru, input logic [AW-1:0] tag, input int wb_wait,
                          input int fill_wait, input bit stray);
    logic [3:0] v;
    bit dirty, exp_err, finished, got_err, both, addr_ok, order_ok, sel_ok, twe;
    int end_exp, wb_exp, fill_exp, base, cyc, end_cyc, wb_n, fill_n;
    logic [3:0] touch;

    v     = ref_victim(sv, lru);
    dirty = (sv & sd & v) != 4'b0;
    if (dirty && wb_wait >= int'(TMO)) begin
      exp_err = 1; wb_exp = TMO; fill_exp = 0; end_exp = 2 + TMO;
    end else begin
      wb_exp = dirty ? wb_wait + 1 : 0;
      base   = dirty ? 3 + wb_wait : 2;
      if (fill_wait >= int'(TMO)) begin
        exp_err = 1; fill_exp = TMO; end_exp = base + TMO;
      end else begin
        exp_err = 0; fill_exp = fill_wait + 1; end_exp = base + fill_wait + 1;
      end
    end

    @(negedge clk);
    check_eq("ready_before", bus.miss_ready, 1);
    bus.miss_valid = 1'b1; bus.miss_addr = addr; bus.set_valid = sv; bus.set_dirty = sd;
    bus.lru_way = lru; bus.victim_tag_addr = tag;
    cyc = 0;
    @(negedge clk);
    cyc = 1;
    bus.miss_valid = 1'b0;
    bus.miss_addr = $urandom; bus.set_valid = 4'($urandom); bus.set_dirty = 4'($urandom);
    bus.lru_way = 4'($urandom);
    check_eq("way_sel_sel", bus.way_sel, v);
    check_eq("ready_busy", bus.miss_ready, 0);

    wb_n = 0; fill_n = 0; addr_ok = 1; order_ok = 1; sel_ok = 1; finished = 0;
    got_err = 0; both = 0; touch = 4'b0; twe = 0; end_cyc = -1;
    while (!finished && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.victim_tag_addr = $urandom;
      bus.wb_ack = 1'b0; bus.fill_ack = 1'b0; bus.miss_valid = 1'b0;
      if (bus.done || bus.err) begin
        finished = 1; end_cyc = cyc; got_err = bus.err; both = bus.done && bus.err;
        touch = bus.lru_touch; twe = bus.tag_we;
      end else begin
        if (bus.way_sel !== v) sel_ok = 0;
        if (bus.wb_req) begin
          if (bus.wb_addr !== line_of(tag)) addr_ok = 0;
          if (bus.fill_req) order_ok = 0;
          if (wb_n == wb_wait) bus.wb_ack = 1'b1;
          if (stray) bus.fill_ack = 1'b1;
          wb_n++;
        end
        if (bus.fill_req) begin
          if (bus.fill_addr !== line_of(addr)) addr_ok = 0;
          if (fill_n == fill_wait) bus.fill_ack = 1'b1;
          if (stray) begin bus.miss_valid = 1'b1; bus.wb_ack = 1'b1; end
          fill_n++;
        end
      end
    end
    bus.wb_ack = 1'b0; bus.fill_ack = 1'b0; bus.miss_valid = 1'b0;

    check_eq("finished", finished, 1);
    check_eq("end_cycle", end_cyc, end_exp);
    check_eq("err_flag", got_err, exp_err);
    check_eq("done_err_excl", both, 0);
    check_eq("wb_cycles", wb_n, wb_exp);
    check_eq("fill_cycles", fill_n, fill_exp);
    check_eq("addr_stable", addr_ok, 1);
    check_eq("fill_after_wb", order_ok, 1);
    check_eq("way_sel_hold", sel_ok, 1);
    check_eq("lru_touch", touch, exp_err ? 4'b0 : v);
    check_eq("tag_we", twe, !exp_err);
    @(negedge clk);
    idle_checks();
  endtask

  initial begin
    logic [3:0] sv, sd, lru;
    int mode;

    rst = 1'b1;
    bus.miss_valid = 0; bus.miss_addr = '0; bus.set_valid = '0; bus.set_dirty = '0;
    bus.lru_way = '0; bus.victim_tag_addr = '0; bus.wb_ack = 0; bus.fill_ack = 0;
    repeat (2) @(negedge clk);
    idle_checks();
    check_eq("rst_addrs", {bus.wb_addr, bus.fill_addr}, 64'h0);
    rst = 1'b0;

    // Directed scenarios
    run_miss(32'h0000_1234, 4'b1011, 4'b0000, 4'b0001, 32'h0000_5555, 0, 2, 0);
    run_miss(32'h0000_8888, 4'hF, 4'h0, 4'b1000, 32'h0000_7777, 0, 0, 0);
    run_miss(32'h0000_4444, 4'hF, 4'b0010, 4'b0010, 32'h0000_ABCF, 3, 1, 0);
    run_miss(32'h1000_0010, 4'hF, 4'h0, 4'b0100, 32'h0, 0, 99, 0);
    run_miss(32'h1000_0020, 4'hF, 4'h0, 4'b0100, 32'h0, 0, TMO - 1, 0);
    run_miss(32'h2000_0030, 4'hF, 4'hF, 4'b0001, 32'h0000_3333, 99, 0, 0);
    run_miss(32'h3000_003C, 4'hF, 4'h0, 4'b0000, 32'h0, 0, 1, 1);

    // Stray acks while idle must be ignored
    @(negedge clk);
    bus.fill_ack = 1'b1; bus.wb_ack = 1'b1;
    @(negedge clk);
    bus.fill_ack = 1'b0; bus.wb_ack = 1'b0;
    idle_checks();

    // Reset in the middle of a writeback
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h5000_0000; bus.set_valid = 4'hF;
    bus.set_dirty = 4'hF; bus.lru_way = 4'b0001; bus.victim_tag_addr = 32'h6000_0000;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.wb_req; i++) @(negedge clk);
    check_eq("rst_wb_seen", bus.wb_req, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("rst_async", {bus.wb_req, bus.miss_ready, bus.fill_req, bus.way_sel},
                7'b0_1_0_0000);
    @(negedge clk);
    rst = 1'b0;
    run_miss(32'h0000_0ABC, 4'hF, 4'b0100, 4'b0100, 32'h0000_1FFF, 1, 0, 0);

    // Random misses
    for (int n = 0; n < 150; n++) begin
      sv = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      sd = 4'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0) lru = 4'b0;
      else if (mode == 1) lru = 4'($urandom);
      else lru = 4'(1 << $urandom_range(0, 3));
      run_miss($urandom, sv, sd, lru, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
               bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
